// File: rtl/fib_index_pkg.sv
// Shared definitions for the Fibonacci index lookup: widths and the FSM state
// encoding that is common with the forward Fibonacci circuit.
package fib_index_pkg;

  localparam int FIB_W       = 20;
  localparam int FIB_IDX_MAX = 31;
  localparam int FIB_IW      = $clog2(FIB_IDX_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OP   = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fib_index_if.sv
// start/ready/done_tick handshake plus the value and result buses of the
// Fibonacci index lookup.
interface fib_index_if
  import fib_index_pkg::*;
#(
  parameter int W  = FIB_W,
  parameter int IW = FIB_IW
);

  logic          start;
  logic [W-1:0]  f;
  logic          ready;
  logic          done_tick;
  logic [IW-1:0] idx;
  logic          exact;

  modport master (
    output start, f,
    input  ready, done_tick, idx, exact
  );

  modport slave (
    input  start, f,
    output ready, done_tick, idx, exact
  );

endinterface

// File: rtl/fib_index.sv
// Iterative FSMD finding the smallest i with fib(i) >= f, and flagging whether
// f is itself a Fibonacci number.
module fib_index
  import fib_index_pkg::*;
#(
  parameter int W  = FIB_W,
  parameter int IW = FIB_IW
) (
  input  logic       clk,
  input  logic       reset,
  fib_index_if.slave bus
);

  state_t        state_reg, state_next;
  logic [W:0]    a_reg, a_next;
  logic [W:0]    b_reg, b_next;
  logic [IW-1:0] n_reg, n_next;
  logic [W-1:0]  f_reg, f_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          exact_reg, exact_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      n_reg     <= '0;
      f_reg     <= '0;
      idx_reg   <= '0;
      exact_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      n_reg     <= n_next;
      f_reg     <= f_next;
      idx_reg   <= idx_next;
      exact_reg <= exact_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    n_next     = n_reg;
    f_next     = f_reg;
    idx_next   = idx_reg;
    exact_next = exact_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          f_next     = bus.f;
          a_next     = '0;
          b_next     = (W + 1)'(1);
          n_next     = '0;
          state_next = ST_OP;
        end
      end
      ST_OP: begin
        // b may wrap on the last step; it is discarded once a reaches f_reg
        if (a_reg >= {1'b0, f_reg}) begin
          idx_next   = n_reg;
          exact_next = (a_reg == {1'b0, f_reg});
          state_next = ST_DONE;
        end else begin
          a_next = b_reg;
          b_next = a_reg + b_reg;
          n_next = n_reg + IW'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.ready     = (state_reg == ST_IDLE);
  assign bus.done_tick = (state_reg == ST_DONE);
  assign bus.idx       = idx_reg;
  assign bus.exact     = exact_reg;

endmodule

// File: tb/tb_fib_index.sv
// Directed and randomized checks of fib_index against a table-driven
// Fibonacci reference.
module tb_fib_index;

  localparam int W  = 20;
  localparam int IW = 5;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  longint fib_tab [0:33];

  fib_index_if #(.W(W), .IW(IW)) bus ();

  fib_index #(.W(W), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Smallest index whose Fibonacci number reaches fv.
  function automatic int ref_idx(input longint fv);
    for (int i = 0; i <= 33; i++)
      if (fib_tab[i] >= fv) return i;
    return -1;
  endfunction

  task automatic run_lookup(input logic [W-1:0] fv, input int poke, output int lat,
                            output logic [IW-1:0] ridx, output logic rexact);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.f     = fv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.f     = W'($urandom());
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done_tick) break;
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.f     = W'(3);
      end else begin
        bus.start = 1'b0;
      end
    end
    if (!bus.done_tick) lat = -1;
    ridx   = bus.idx;
    rexact = bus.exact;
    $display("lookup f=%0d idx=%0d exact=%0d latency=%0d", fv, ridx, rexact, lat);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done_tick), 32'd0);
  endtask

  initial begin
    int            lat;
    int            exp_i;
    logic [IW-1:0] gi;
    logic          ge;
    logic [W-1:0]  fv;
    int            dcount;
    logic [W-1:0]  dir_f [6];
    int            dir_i [6];
    int            dir_e [6];

    checks   = 0;
    failures = 0;
    fib_tab[0] = 0;
    fib_tab[1] = 1;
    for (int i = 2; i <= 33; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

    dir_f = '{20'd0, 20'd1, 20'd14, 20'd832040, 20'hFFFFF, 20'd13};
    dir_i = '{0, 1, 8, 30, 31, 7};
    dir_e = '{1, 1, 0, 1, 0, 1};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.f     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_done", 32'(bus.done_tick), 32'd0);
    check("reset_idx", 32'(bus.idx), 32'd0);
    check("reset_exact", 32'(bus.exact), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_lookup(dir_f[k], 0, lat, gi, ge);
      check("dir_idx", 32'(gi), 32'(dir_i[k]));
      check("dir_exact", 32'(ge), 32'(dir_e[k]));
      check("dir_latency", 32'(lat), 32'(dir_i[k] + 2));
    end

    // Reset in the fifth op cycle of f=100 must abort with no completion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.f     = 20'd100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_done", 32'(bus.done_tick), 32'd0);
    check("abort_idx", 32'(bus.idx), 32'd0);
    check("abort_exact", 32'(bus.exact), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done_tick) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    $display("abort f=100 done_ticks_after_reset=%0d", dcount);
    run_lookup(20'd100, 0, lat, gi, ge);
    check("f100_idx", 32'(gi), 32'd12);
    check("f100_exact", 32'(ge), 32'd0);
    check("f100_latency", 32'(lat), 32'd14);

    // A start pulse mid-run must be ignored.
    run_lookup(20'd55, 3, lat, gi, ge);
    check("busy_idx", 32'(gi), 32'd10);
    check("busy_exact", 32'(ge), 32'd1);
    check("busy_latency", 32'(lat), 32'd12);
    check("busy_idle_after", 32'(bus.ready), 32'd1);

    for (int i = 0; i <= 30; i++) begin
      run_lookup(W'(fib_tab[i]), 0, lat, gi, ge);
      exp_i = (i == 2) ? 1 : i;
      check("rt_idx", 32'(gi), 32'(exp_i));
      check("rt_exact", 32'(ge), 32'd1);
      check("rt_latency", 32'(lat), 32'(exp_i + 2));
    end

    for (int r = 0; r < 30; r++) begin
      if (r % 2 == 0) begin
        fv = W'($urandom());
      end else begin
        fv = W'(fib_tab[$urandom_range(3, 30)] + longint'($urandom_range(0, 2)) - 1);
      end
      exp_i = ref_idx(longint'(fv));
      run_lookup(fv, 0, lat, gi, ge);
      check("rnd_idx", 32'(gi), 32'(exp_i));
      check("rnd_exact", 32'(ge), 32'(fib_tab[exp_i] == longint'(fv)));
      check("rnd_latency", 32'(lat), 32'(exp_i + 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
